// File: rtl/apb_service_unit_mc.sv
// APB interrupt/event service unit: per-source level/edge capture under an enable mask,
// W1S/W1C pending, and a claim/complete handshake with a single-level service FSM.
module apb_service_unit_mc #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned N_SRC          = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [N_SRC-1:0]          signal_i,
  output logic                      irq_o
);

  localparam int unsigned ID_W = $clog2(N_SRC + 1);

  localparam logic [2:0] REG_ENABLE   = 3'd0;
  localparam logic [2:0] REG_PENDING  = 3'd1;
  localparam logic [2:0] REG_SET      = 3'd2;
  localparam logic [2:0] REG_CLEAR    = 3'd3;
  localparam logic [2:0] REG_MODE     = 3'd4;
  localparam logic [2:0] REG_CLAIM    = 3'd5;
  localparam logic [2:0] REG_COMPLETE = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  typedef enum logic {S_IDLE, S_SVC} state_t;

  state_t             state_q, state_n;
  logic [N_SRC-1:0]   enable_q, mode_q, pend_q, sig_q;
  logic [ID_W-1:0]    active_id_q;

  logic               addr_bad, acc, wr, rd_sel;
  logic [2:0]         sel;
  logic [N_SRC-1:0]   hit, elig, set_w, clr_w, claim_clr, pend_n;
  logic [ID_W-1:0]    top_id;
  logic               claim_rd, cmpl_wr, id_match;
  logic               claim_fire, cmpl_fire;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^PADDR[1:0];

  // APB decode; any upper address bit set makes the access an error with no side effect
  assign addr_bad = |PADDR[APB_ADDR_WIDTH-1:5];
  assign sel      = PADDR[4:2];
  assign acc      = PSEL & PENABLE & ~addr_bad;
  assign wr       = acc & PWRITE;
  assign rd_sel   = PSEL & ~PWRITE & ~addr_bad;
  assign claim_rd = acc & ~PWRITE & (sel == REG_CLAIM);
  assign cmpl_wr  = wr & (sel == REG_COMPLETE);
  assign id_match = (PWDATA[ID_W-1:0] == active_id_q);
  assign set_w    = (wr && sel == REG_SET)   ? PWDATA[N_SRC-1:0] : '0;
  assign clr_w    = (wr && sel == REG_CLEAR) ? PWDATA[N_SRC-1:0] : '0;

  assign PREADY   = 1'b1;
  assign PSLVERR  = PSEL & PENABLE & addr_bad;

  assign hit  = enable_q & ((mode_q & signal_i & ~sig_q) | (~mode_q & signal_i));
  assign elig = pend_q & enable_q;

  // Highest eligible index wins; ID is index+1 so that 0 means none
  always_comb begin
    top_id = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (elig[i]) top_id = ID_W'(i + 1);
    end
  end

  always_comb begin
    claim_clr = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      claim_clr[i] = claim_fire && (top_id == ID_W'(i + 1));
    end
  end

  // CLEAR dominates; capture and SET dominate a same-cycle claim
  assign pend_n = ((pend_q & ~claim_clr) | hit | set_w) & ~clr_w;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sig_q       <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      pend_q      <= '0;
      active_id_q <= '0;
    end else begin
      sig_q  <= signal_i;
      pend_q <= pend_n;
      if (wr && sel == REG_ENABLE) enable_q <= PWDATA[N_SRC-1:0];
      if (wr && sel == REG_MODE)   mode_q   <= PWDATA[N_SRC-1:0];
      if (claim_fire)              active_id_q <= top_id;
      else if (cmpl_fire)          active_id_q <= '0;
    end
  end

  // Service FSM: state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_n;
  end

  // Service FSM: next state
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (claim_rd && (elig != '0)) state_n = S_SVC;
      S_SVC:   if (cmpl_wr && id_match)      state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Service FSM: outputs
  always_comb begin
    claim_fire = 1'b0;
    cmpl_fire  = 1'b0;
    irq_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        claim_fire = claim_rd && (elig != '0);
        irq_o      = (elig != '0);
      end
      S_SVC:   cmpl_fire = cmpl_wr && id_match;
      default: ;
    endcase
  end

  always_comb begin
    PRDATA = '0;
    if (rd_sel) begin
      case (sel)
        REG_ENABLE:  PRDATA = 32'(enable_q);
        REG_PENDING: PRDATA = 32'(pend_q);
        REG_MODE:    PRDATA = 32'(mode_q);
        REG_CLAIM:   PRDATA = (state_q == S_IDLE) ? 32'(top_id) : 32'd0;
        REG_STATUS:  PRDATA = {(state_q == S_SVC), 31'(active_id_q)};
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_service_unit_mc.sv
// Scoreboard bench for apb_service_unit_mc: expected read data is queued before each
// access and popped when the access-phase data is sampled.
module tb_apb_service_unit_mc;

  localparam logic [11:0] A_ENABLE   = 12'h000;
  localparam logic [11:0] A_PENDING  = 12'h004;
  localparam logic [11:0] A_SET      = 12'h008;
  localparam logic [11:0] A_CLEAR    = 12'h00C;
  localparam logic [11:0] A_MODE     = 12'h010;
  localparam logic [11:0] A_CLAIM    = 12'h014;
  localparam logic [11:0] A_COMPLETE = 12'h018;
  localparam logic [11:0] A_STATUS   = 12'h01C;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] signal_i;
  logic        irq_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] rd_data;
  logic        rd_err;

  apb_service_unit_mc #(.APB_ADDR_WIDTH(12), .N_SRC(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .signal_i(signal_i), .irq_o(irq_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge HCLK); PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge HCLK); PENABLE = 1'b1;
    @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Queue the expected value, then run a read and sample the access-phase data
  task automatic sb_read(input logic [11:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    @(negedge HCLK); PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge HCLK); PENABLE = 1'b1;
    #1; rd_data = PRDATA; rd_err = PSLVERR;
    @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h want 0", PRDATA); end
    checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR); end
    @(negedge HCLK); HRESETn = 1'b1;
    sb_read(A_ENABLE, 32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL reset_enable: got %h want %h", rd_data, exp); end
    sb_read(A_STATUS, 32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL reset_status: got %h want %h", rd_data, exp); end
  endtask

  task automatic test_level_pulse;
    apb_write(A_ENABLE, 32'h1);
    signal_i = 32'h1;
    @(negedge HCLK); signal_i = 32'h0;
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL pulse_irq: got %b want 1", irq_o); end
    sb_read(A_PENDING, 32'h1);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL pulse_pending: got %h want %h", rd_data, exp); end
    sb_read(A_CLAIM, 32'd1);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL pulse_claim: got %h want %h", rd_data, exp); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL pulse_irq_after_claim: got %b want 0", irq_o); end
    sb_read(A_STATUS, 32'h8000_0001);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL pulse_status: got %h want %h", rd_data, exp); end
    apb_write(A_COMPLETE, 32'd1);
    sb_read(A_STATUS, 32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL pulse_status_done: got %h want %h", rd_data, exp); end
  endtask

  task automatic test_priority;
    apb_write(A_ENABLE, 32'hFFFF_FFFF);
    apb_write(A_MODE, 32'hFFFF_FFFF);
    signal_i = (32'h1 << 3) | (32'h1 << 17);
    @(negedge HCLK); signal_i = 32'h0;
    sb_read(A_CLAIM, 32'd18);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL prio_claim1: got %0d want %0d", rd_data, exp); end
    sb_read(A_CLAIM, 32'd0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL prio_claim_nested: got %0d want %0d", rd_data, exp); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL prio_irq_in_service: got %b want 0", irq_o); end
    apb_write(A_COMPLETE, 32'd18);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL prio_irq_after_complete: got %b want 1", irq_o); end
    sb_read(A_CLAIM, 32'd4);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL prio_claim2: got %0d want %0d", rd_data, exp); end
    apb_write(A_COMPLETE, 32'd4);
  endtask

  task automatic test_edge_hold;
    signal_i = 32'h1 << 5;
    repeat (10) @(negedge HCLK);
    sb_read(A_PENDING, 32'h20);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL edge_pending: got %h want %h", rd_data, exp); end
    sb_read(A_CLAIM, 32'd6);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL edge_claim: got %0d want %0d", rd_data, exp); end
    sb_read(A_PENDING, 32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL edge_no_repend: got %h want %h", rd_data, exp); end
    apb_write(A_COMPLETE, 32'd6);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL edge_irq_done: got %b want 0", irq_o); end
    signal_i = 32'h0;
  endtask

  task automatic test_level_hold;
    apb_write(A_MODE, 32'h0);
    signal_i = 32'h1 << 2;
    @(negedge HCLK);
    sb_read(A_CLAIM, 32'd3);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL level_claim: got %0d want %0d", rd_data, exp); end
    sb_read(A_PENDING, 32'h4);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL level_repend: got %h want %h", rd_data, exp); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL level_irq_in_service: got %b want 0", irq_o); end
    apb_write(A_COMPLETE, 32'd3);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL level_irq_rerequest: got %b want 1", irq_o); end
    signal_i = 32'h0;
    sb_read(A_CLAIM, 32'd3);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL level_claim2: got %0d want %0d", rd_data, exp); end
    apb_write(A_COMPLETE, 32'd3);
    sb_read(A_PENDING, 32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL level_pending_clear: got %h want %h", rd_data, exp); end
  endtask

  task automatic test_set_clear;
    apb_write(A_SET, 32'h30);
    apb_write(A_CLEAR, 32'h10);
    sb_read(A_PENDING, 32'h20);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL setclr_pending: got %h want %h", rd_data, exp); end
    apb_write(A_CLEAR, 32'h20);
    apb_write(A_MODE, 32'hFFFF_FFFF);
    // CLEAR access phase coincides with a rising edge on bit 0
    @(negedge HCLK); PSEL = 1'b1; PWRITE = 1'b1; PADDR = A_CLEAR; PWDATA = 32'h1; PENABLE = 1'b0;
    @(negedge HCLK); PENABLE = 1'b1; signal_i = 32'h1;
    @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    sb_read(A_PENDING, 32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL clear_beats_edge: got %h want %h", rd_data, exp); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL clear_beats_edge_irq: got %b want 0", irq_o); end
    signal_i = 32'h0;
  endtask

  task automatic test_errors_and_reset;
    apb_write(A_SET, 32'h4);
    sb_read(A_CLAIM, 32'd3);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL err_claim: got %0d want %0d", rd_data, exp); end
    apb_write(A_COMPLETE, 32'd7);
    sb_read(A_STATUS, 32'h8000_0003);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL bad_complete_status: got %h want %h", rd_data, exp); end
    sb_read(12'h040, 32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp || rd_err !== 1'b1) begin
      errors++; $display("FAIL unmapped_read: got data %h err %b want %h err 1", rd_data, rd_err, exp);
    end
    apb_write(12'h020, 32'h0);
    sb_read(A_ENABLE, 32'hFFFF_FFFF);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL unmapped_write_ignored: got %h want %h", rd_data, exp); end
    sb_read(A_SET, 32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp || rd_err !== 1'b0) begin
      errors++; $display("FAIL wo_read: got data %h err %b want %h err 0", rd_data, rd_err, exp);
    end
    apb_write(A_PENDING, 32'hFFFF);
    sb_read(A_PENDING, 32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL ro_write_ignored: got %h want %h", rd_data, exp); end
    apb_write(A_SET, 32'h100);
    // Reset lands in the middle of a COMPLETE access phase
    @(negedge HCLK); PSEL = 1'b1; PWRITE = 1'b1; PADDR = A_COMPLETE; PWDATA = 32'd3; PENABLE = 1'b0;
    @(negedge HCLK); PENABLE = 1'b1;
    #1; HRESETn = 1'b0;
    #1; PWRITE = 1'b0; PADDR = A_STATUS;
    #1;
    checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_mid_status: got %h want 0", PRDATA); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_mid_irq: got %b want 0", irq_o); end
    PADDR = A_PENDING;
    #1;
    checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_mid_pending: got %h want 0", PRDATA); end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1;
    sb_read(A_ENABLE, 32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL reset_mid_enable: got %h want %h", rd_data, exp); end
  endtask

  initial begin
    HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    signal_i = '0;
    test_reset();
    test_level_pulse();
    test_priority();
    test_edge_hold();
    test_level_hold();
    test_set_clear();
    test_errors_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_service_unit_mc.md
# apb_service_unit_mc

Parametrised APB interrupt/event service unit, the next generation of the single-register-bank service unit. It collects `N_SRC` synchronous request lines and captures each one in level or rising-edge mode under an enable mask. Software is served through an explicit claim/complete handshake with a two-state service FSM, plus atomic write-1-to-set and write-1-to-clear of the pending bits. It sits on the peripheral APB bus and drives one interrupt line to the core's interrupt input.

## Interface
- `APB_ADDR_WIDTH`, 12, APB address width (4 KB slave).
- `N_SRC`, 32, number of sources, legal 1..32. `ID_W = $clog2(N_SRC+1)`.
- `HCLK`  in  1  clock.
- `HRESETn`  in  1  reset. Asynchronous, active-low.
- `PADDR`  in  APB_ADDR_WIDTH  byte address. Only `PADDR[4:2]` is decoded; `PADDR[APB_ADDR_WIDTH-1:5]` must be 0.
- `PWDATA`  in  32  write data.
- `PWRITE`, `PSEL`, `PENABLE`  in  1  APB control.
- `PRDATA`  out  32  read data. Combinational, valid in the access phase.
- `PREADY`  out  1  tied to 1.
- `PSLVERR`  out  1  error response for unmapped accesses.
- `signal_i`  in  N_SRC  source requests, synchronous to HCLK.
- `irq_o`  out  1  service request to the core.

## Operation
- Register map (byte offset). Bits at or above N_SRC read 0 and ignore writes.
  - 0x00 ENABLE: RW.
  - 0x04 PENDING: RO.
  - 0x08 SET: WO, write-1-sets pending.
  - 0x0C CLEAR: WO, write-1-clears pending.
  - 0x10 MODE: RW, 1 = rising edge, 0 = level.
  - 0x14 CLAIM: RO with side effect.
  - 0x18 COMPLETE: WO.
  - 0x1C STATUS: RO, bit31 = IN_SERVICE, bits[ID_W-1:0] = active ID.
- Access rules:
  - Any access with upper address bits nonzero → `PSLVERR=1`, read 0, no side effect.
  - Reads of WO registers return 0 with `PSLVERR=0`.
  - Writes to RO registers are ignored with `PSLVERR=0`.
- Capture, per bit i:
  - `hit_i = ENABLE[i] & (MODE[i] ? signal_i[i] & ~sig_q[i] : signal_i[i])`.
  - `sig_q` is a register sampling `signal_i` every cycle.
- Pending next-state, per bit:
  - `pend_n = ((pend_q & ~claim_clr) | hit | set_w) & ~clr_w`.
  - CLEAR beats SET and capture. Capture/SET beats a claim in the same cycle.
- Eligibility and ID:
  - `elig = pend_q & ENABLE`.
  - Priority is the highest index. ID = index+1; ID 0 means none.
- Service FSM:
  - IDLE → IN_SERVICE on a CLAIM read when `elig != 0`. The read returns the ID, loads `active_id`, and clears that pending bit (`claim_clr`).
  - CLAIM read in IDLE with `elig == 0` returns 0, no change.
  - CLAIM read in IN_SERVICE returns 0, no change. No nesting.
  - IN_SERVICE → IDLE on a COMPLETE write with `PWDATA[ID_W-1:0] == active_id`; `active_id` then clears to 0.
  - COMPLETE writes with a mismatched ID, or in IDLE, are ignored.
- `irq_o = (state == IDLE) && (elig != 0)`. It is built from registers only, with no combinational path from APB or `signal_i`.
- Level sources still high after a claim re-pend on the next cycle. This is intended: they re-request after COMPLETE until the source is deasserted.
- Disabled sources keep existing pending bits but cannot be claimed and do not raise `irq_o`.

## Timing
- Reset values are all 0: ENABLE, MODE, PENDING, `sig_q`, `active_id`, state = IDLE, `irq_o = 0`, `PRDATA = 0`, `PSLVERR = 0`.
- A source high at reset release in edge mode is seen as an edge in the first cycle.
- Capture latency:
  - `signal_i` high before clock edge k (edge-qualified) → PENDING set after edge k.
  - `irq_o` high in the same cycle (after edge k).
- APB access phase (`PSEL & PENABLE`) completes in one cycle. Register updates land at the clock edge that ends the access phase.
- CLAIM:
  - The read data is the ID from `elig` as it stands during the access phase.
  - State and pending update at the end of that cycle.
  - `irq_o` falls the next cycle.
- COMPLETE: `irq_o` may reassert in the cycle after the write edge if `elig != 0`.
- Reset asserted mid-transaction aborts it. All state returns to reset values asynchronously.

## Test plan
- Reset, then ENABLE=0x1, MODE=0, pulse `signal_i[0]` for 1 cycle → PENDING=0x1 and `irq_o=1` after the next edge; CLAIM reads 1; `irq_o=0`; STATUS=0x8000_0001.
- ENABLE=0xFFFF_FFFF, MODE=0xFFFF_FFFF, `signal_i` bits 3 and 17 rise together:
  - first CLAIM → 18; second CLAIM before COMPLETE → 0.
  - COMPLETE 18 → `irq_o=1` next cycle; next CLAIM → 4.
- Edge mode, `signal_i[5]` held high 10 cycles → exactly one pending event. After claim/complete, PENDING=0 and `irq_o=0`.
- Level mode, `signal_i[2]` held high → CLAIM 3, PENDING[2] re-sets the next cycle, `irq_o` stays 0 until COMPLETE 3, then rises.
- SET write 0x30 and CLEAR write 0x10 in successive cycles → PENDING=0x20. CLEAR 0x1 coinciding with an edge on bit 0 → bit 0 stays 0.
- COMPLETE 7 while `active_id=3` → still IN_SERVICE. Read at offset 0x40 → `PSLVERR=1`, PRDATA=0. Assert `HRESETn` low mid-service → STATUS=0, `irq_o=0` immediately.
